// File: rtl/sram_pkg.sv
// sram_pkg: shared types for the SRAM responder and its initiator.
//   sram_state_t : 2-bit status encoding driven on sram_state
//                  (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
package sram_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } sram_state_t;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: up-counter with synchronous clear and programmable wrap.
//   clk, n_rst    : clock (rising edge) and async active-low reset
//   clear         : forces the count to zero (takes priority over enable)
//   count_enable  : advance by one; wraps to zero after rollover_val
//   rollover_val  : last value reached before wrapping
//   count_out     : current count
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out
);

  logic [NUM_BITS-1:0] count_q;
  logic [NUM_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = '0;
      else                         count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: single-port word SRAM with fixed access latency and
// protocol error reporting, standing in for the hard macro.
//   clk, n_rst  : clock (rising edge), async active-low reset
//   wen, ren    : write / read request (held by initiator through BUSY)
//   addr, wdata : word address and write data, sampled at commit
//   rdata       : registered read data, valid from ACCESS until next read
//   sram_state  : registered FSM state (FREE/BUSY/ACCESS/ERROR)
//
// Handshake: a request is offered by raising wen or ren while sram_state is
// FREE; it is accepted on that edge. The initiator keeps the request stable
// until sram_state leaves BUSY; completion is signalled by exactly one cycle
// of ACCESS (success) or ERROR (rejected), after which the block is FREE.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        sram_state
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  sram_state_t       state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  count;
  logic              cnt_clear, cnt_en, wr_commit;
  logic              commit, in_range;
  logic [IDX_W-1:0]  idx;

  flex_counter #(.NUM_BITS(CNT_W)) u_lat_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (LAST_CNT),
    .count_out    (count)
  );

  // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign idx      = addr[IDX_W-1:0];
  // Last BUSY cycle: request lines are only trusted here.
  assign commit   = (state_q == BUSY) && (count == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      FREE: begin
        cnt_clear = 1'b1;
        if (wen || ren) state_d = BUSY;
      end
      BUSY: begin
        cnt_en = 1'b1;
        if (commit) begin
          if (wen && !ren && in_range) begin
            wr_commit = 1'b1;
            state_d   = ACCESS;
          end else if (ren && !wen && in_range) begin
            rdata_d = mem[idx];
            state_d = ACCESS;
          end else begin
            // conflicting, withdrawn or out-of-range request
            state_d = ERROR;
          end
        end
      end
      // Request lines are ignored here so a held request cannot repeat.
      ACCESS:  state_d = FREE;
      ERROR:   state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FREE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[idx] <= wdata;
  end

  assign rdata      = rdata_q;
  assign sram_state = state_q;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
  import sram_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 512;
  localparam int LAT    = 2;

  typedef struct packed {
    logic [1:0]        state;
    logic              chk_rdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic              clk;
  logic              n_rst;
  logic              wen, ren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        sram_state;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;

  // reference model
  logic [DATA_W-1:0] mem_m [1 << ADDR_W];
  bit                written [1 << ADDR_W];
  logic [DATA_W-1:0] rdata_m = '0;
  bit                rdata_known = 1;

  sram_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .wen        (wen),
    .ren        (ren),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .sram_state (sram_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  // monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sram_state", {30'd0, sram_state}, {30'd0, e.state});
      if (e.chk_rdata) check("rdata", rdata, e.rdata);
    end
  end

  // driver: drive one cycle of inputs and record what the DUT should show
  task automatic tick(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    wen = w; ren = r; addr = a; wdata = d;
    e.state = st; e.chk_rdata = rdata_known; e.rdata = rdata_m;
    exp_q.push_back(e);
  endtask

  // One full transaction: values offered at acceptance (w0..d0), values
  // present at the commit cycle (wc..dc); hold keeps them through ACCESS/ERROR.
  task automatic request(input logic w0, input logic r0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0,
                         input logic wc, input logic rc, input logic [ADDR_W-1:0] ac,
                         input logic [DATA_W-1:0] dc, input bit hold);
    logic [1:0] res;
    tick(w0, r0, a0, d0, FREE);
    for (int i = 0; i < LAT - 1; i++) tick(w0, r0, a0, d0, BUSY);
    tick(wc, rc, ac, dc, BUSY);
    if (int'(ac) < DEPTH && wc && !rc) begin
      mem_m[ac] = dc; written[ac] = 1; res = ACCESS;
    end else if (int'(ac) < DEPTH && rc && !wc) begin
      rdata_m = mem_m[ac]; rdata_known = written[ac]; res = ACCESS;
    end else begin
      res = ERROR;
    end
    if (hold) tick(wc, rc, ac, dc, res);
    else      tick(1'b0, 1'b0, ac, dc, res);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    request(1'b1, 1'b0, a, d, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    request(1'b0, 1'b1, a, '0, 1'b0, 1'b1, a, '0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, '0, FREE);
  endtask

  initial begin
    n_rst = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) written[i] = 0;

    // reset state
    #2;
    check("reset_state", {30'd0, sram_state}, {30'd0, FREE});
    check("reset_rdata", rdata, '0);
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
    mon_en = 1;
    repeat (3) idle();

    // write then read
    do_write(10'd5, 32'hDEADBEEF);
    do_read(10'd5);
    idle();

    // protocol errors: rdata must stay DEADBEEF
    request(1'b1, 1'b1, 10'd5, 32'h1, 1'b1, 1'b1, 10'd5, 32'h1, 1'b0);
    request(1'b1, 1'b0, 10'd7, 32'h2, 1'b0, 1'b0, 10'd7, 32'h2, 1'b0);
    request(1'b1, 1'b0, 10'd600, 32'h3, 1'b1, 1'b0, 10'd600, 32'h3, 1'b0);
    request(1'b0, 1'b1, 10'd600, 32'h0, 1'b0, 1'b1, 10'd600, 32'h0, 1'b0);
    idle();

    // two-word beat with wen held across ACCESS
    request(1'b1, 1'b0, 10'd16, 32'h11111111, 1'b1, 1'b0, 10'd16, 32'h11111111, 1'b1);
    request(1'b1, 1'b0, 10'd17, 32'h22222222, 1'b1, 1'b0, 10'd17, 32'h22222222, 1'b0);
    do_read(10'd16);
    do_read(10'd17);

    // late address: only the committed address is written
    do_write(10'd0, 32'h12345678);
    request(1'b1, 1'b0, 10'd0, 32'hA5A5A5A5, 1'b1, 1'b0, 10'd9, 32'hA5A5A5A5, 1'b0);
    do_read(10'd0);
    do_read(10'd9);

    // reset mid-BUSY drops the in-flight write
    do_write(10'd3, 32'h00000077);
    tick(1'b1, 1'b0, 10'd3, 32'h5, FREE);
    tick(1'b1, 1'b0, 10'd3, 32'h5, BUSY);
    @(negedge clk);
    #1;
    mon_en = 0;
    n_rst = 1'b0;
    wen = 1'b0;
    #1;
    check("midbusy_reset_state", {30'd0, sram_state}, {30'd0, FREE});
    check("midbusy_reset_rdata", rdata, '0);
    exp_q.delete();
    rdata_m = '0; rdata_known = 1;
    @(posedge clk);
    #3 n_rst = 1'b1;
    mon_en = 1;
    idle();
    do_read(10'd3);

    // randomized traffic over a small address pool plus out-of-range
    for (int i = 0; i < 16; i++) do_write(ADDR_W'(i + 32), $urandom);
    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      logic [ADDR_W-1:0] a, a2;
      logic [DATA_W-1:0] d;
      bit hold;
      kind = $urandom_range(0, 9);
      a    = ADDR_W'($urandom_range(32, 47));
      a2   = ADDR_W'($urandom_range(32, 47));
      d    = $urandom;
      hold = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a2 = ADDR_W'($urandom_range(DEPTH, 1023));
      case (kind)
        0, 1, 2: request(1'b1, 1'b0, a, d, 1'b1, 1'b0, a2, d, hold);
        3, 4, 5: request(1'b0, 1'b1, a, d, 1'b0, 1'b1, a2, d, hold);
        6:       request(1'b1, 1'b1, a, d, 1'b1, 1'b1, a2, d, hold);
        7:       request(1'b0, 1'b1, a, d, 1'b0, 1'b0, a2, d, hold);
        8:       request(1'b1, 1'b0, a, d, 1'b0, 1'b1, a2, d, hold);
        default: begin
          request(1'b1, 1'b0, a, d, 1'b1, 1'b0, a2, d, hold);
          do_read(a2);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle();
    end

    repeat (3) idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
